// File: rtl/mux_sel_rr_arbiter_pkg.sv
// Shared types and the round-robin search for the 8-way select arbiter.
package mux_sel_rr_arbiter_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Returns {found, index} of the first set request at or after start, wrapping.
  // Scanning from the far end down lets the nearest hit win the last assignment.
  function automatic logic [SEL_W:0] rr_pick(input logic [N_REQ-1:0] req,
                                             input logic [SEL_W-1:0] start);
    logic [SEL_W:0]   res;
    logic [SEL_W-1:0] idx;
    res = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = start + SEL_W'(i);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

// File: rtl/mux_8x1.sv
// Plain 8-to-1 single-bit multiplexer.
module mux_8x1 (
  input  logic [7:0] i,
  input  logic [2:0] s,
  output logic       y
);

  assign y = i[s];

endmodule

// File: rtl/mux_sel_rr_arbiter.sv
// Round-robin arbiter with bounded bursts; the granted requester's data bit
// is steered to y through an 8:1 mux.
module mux_sel_rr_arbiter
  import mux_sel_rr_arbiter_pkg::*;
#(
  parameter int BURST_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] d,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] s,
  output logic             valid,
  output logic             y
);

  localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

  arb_state_e       state_p0, state_nxt;
  logic [SEL_W-1:0] ptr_p0, ptr_nxt;
  logic [3:0]       cnt_p0, cnt_nxt;
  logic [SEL_W-1:0] s_nxt;
  logic [N_REQ-1:0] gnt_nxt;
  logic [SEL_W-1:0] start;
  logic [SEL_W:0]   pick;
  logic             rearb;
  logic             raw;

  assign pick = rr_pick(req, start);

  always_comb begin
    state_nxt = state_p0;
    ptr_nxt   = ptr_p0;
    cnt_nxt   = cnt_p0;
    s_nxt     = s;
    start     = ptr_p0;
    rearb     = 1'b0;

    if (state_p0 == IDLE) begin
      rearb = 1'b1;
    end else if (req[s] && (cnt_p0 < BURST_LIM)) begin
      cnt_nxt = cnt_p0 + 4'd1;
    end else begin
      // Burst spent or holder dropped: search starts just past the holder.
      start = s + SEL_W'(1);
      rearb = 1'b1;
    end

    if (rearb) begin
      if (pick[SEL_W]) begin
        state_nxt = GRANT;
        s_nxt     = pick[SEL_W-1:0];
        cnt_nxt   = 4'd1;
        ptr_nxt   = pick[SEL_W-1:0] + SEL_W'(1);
      end else begin
        state_nxt = IDLE;
        s_nxt     = '0;
        cnt_nxt   = '0;
      end
    end

    gnt_nxt = (state_nxt == GRANT) ? (N_REQ'(1) << s_nxt) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= IDLE;
      ptr_p0   <= '0;
      cnt_p0   <= '0;
      s        <= '0;
      gnt      <= '0;
    end else begin
      state_p0 <= state_nxt;
      ptr_p0   <= ptr_nxt;
      cnt_p0   <= cnt_nxt;
      s        <= s_nxt;
      gnt      <= gnt_nxt;
    end
  end

  assign valid = (state_p0 == GRANT);

  mux_8x1 u_mux (
    .i (d),
    .s (s),
    .y (raw)
  );

  assign y = raw & valid;

endmodule

// File: tb/tb_mux_sel_rr_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a
// behavioural round-robin model.
module tb_mux_sel_rr_arbiter;

  localparam int BM = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] d;
  logic [7:0] gnt;
  logic [2:0] s;
  logic       valid;
  logic       y;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state: holder index, cycles in current burst, search start.
  bit m_valid;
  int m_s;
  int m_cnt;
  int m_ptr;
  int streak;

  mux_sel_rr_arbiter #(.BURST_MAX(BM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .d     (d),
    .gnt   (gnt),
    .s     (s),
    .valid (valid),
    .y     (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0;
    m_s     = 0;
    m_cnt   = 0;
    m_ptr   = 0;
    streak  = 0;
  endtask

  task automatic model_step(input logic [7:0] r);
    bit arb;
    bit found;
    int first;
    int k;
    arb = 1;
    first = m_ptr;
    if (m_valid) begin
      if (r[m_s] && m_cnt < BM) begin
        m_cnt++;
        arb = 0;
      end else begin
        first = (m_s + 1) % 8;
      end
    end
    if (arb) begin
      found = 0;
      for (int off = 0; off < 8; off++) begin
        k = (first + off) % 8;
        if (!found && r[k]) begin
          found   = 1;
          m_valid = 1;
          m_s     = k;
          m_cnt   = 1;
          m_ptr   = (k + 1) % 8;
        end
      end
      if (!found) begin
        m_valid = 0;
        m_s     = 0;
        m_cnt   = 0;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [7:0] exp_gnt;
    exp_gnt = m_valid ? (8'd1 << m_s) : 8'd0;
    chk({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
    chk({tag, "_s"}, 32'(s), m_valid ? 32'(m_s) : 32'd0);
    chk({tag, "_valid"}, 32'(valid), 32'(m_valid));
    chk({tag, "_y"}, 32'(y), m_valid ? 32'(d[m_s]) : 32'd0);
  endtask

  // One clock: apply inputs, let the edge happen, advance the model, compare.
  task automatic cyc(input logic [7:0] r, input logic [7:0] dd, input string tag,
                     input bit props);
    bit   pv;
    int   ps;
    bit   oth;
    req = r;
    d   = dd;
    pv  = valid;
    ps  = int'(s);
    oth = pv && ((r & ~(8'd1 << ps)) != 8'd0);
    @(posedge clk);
    model_step(r);
    #1;
    check_outputs(tag);
    if (props) begin
      chk("onehot", 32'($countones(gnt) <= 1), 32'd1);
      chk("s_vs_gnt", 32'(gnt), valid ? 32'(8'd1 << s) : 32'd0);
      chk("y_vs_d", 32'(y), 32'(d[s] & valid));
      if (valid && pv && int'(s) == ps && oth) streak++;
      else streak = valid ? 1 : 0;
      chk("burst_bound", 32'(streak <= BM), 32'd1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_s", 32'(s), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    req   = '0;
    d     = '0;
    rst_n = 1'b1;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("por_gnt", 32'(gnt), 32'd0);
    chk("por_s", 32'(s), 32'd0);
    chk("por_valid", 32'(valid), 32'd0);
    chk("por_y", 32'(y), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle with no requests.
    for (int i = 0; i < 10; i++) cyc(8'h00, 8'hff, "idle", 1'b1);

    // Single requester keeps the grant across burst boundaries.
    for (int i = 0; i < 12; i++) begin
      cyc(8'h04, 8'h04, "solo", 1'b1);
      chk("solo_fixed_gnt", 32'(gnt), 32'h04);
      chk("solo_fixed_y", 32'(y), 32'd1);
    end

    // Two requesters at the ends alternate every BM cycles with 7->0 wrap.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      cyc(8'h81, 8'h80, "alt", 1'b1);
      chk("alt_s", 32'(s), ((i / BM) % 2 == 0) ? 32'd0 : 32'd7);
    end

    // Holder drops, another takes over at the same edge.
    do_reset();
    cyc(8'h08, 8'h00, "hand_a", 1'b1);
    chk("hand_s3", 32'(s), 32'd3);
    cyc(8'h20, 8'h20, "hand_b", 1'b1);
    chk("hand_s5", 32'(s), 32'd5);
    chk("hand_valid", 32'(valid), 32'd1);
    cyc(8'h00, 8'h00, "hand_idle", 1'b1);

    // Asynchronous reset in the middle of a burst at index 6.
    do_reset();
    cyc(8'h40, 8'hff, "mid_a", 1'b1);
    cyc(8'h40, 8'hff, "mid_b", 1'b1);
    chk("mid_s6", 32'(s), 32'd6);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_gnt", 32'(gnt), 32'd0);
    chk("async_s", 32'(s), 32'd0);
    chk("async_valid", 32'(valid), 32'd0);
    chk("async_y", 32'(y), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(8'hff, 8'hff, "post_rst", 1'b1);
    chk("post_rst_s0", 32'(s), 32'd0);

    // Random traffic: mix of dense and sparse request patterns.
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] r;
      r = 8'($urandom);
      if ($urandom_range(0, 3) == 0) r = r & 8'($urandom);
      if ($urandom_range(0, 7) == 0) r = 8'h00;
      cyc(r, 8'($urandom), "rand", 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
